ah_snoopable_fifo_param: RTL and testbench
==========================================

// Module: ah_snoopable_fifo_param
// PURPOSE
//  Parametrised successor of the fixed 32-deep snoopable FIFO: a register-based valid/ready FIFO
//  with a content snoop port that compares a key field of every live entry against a probe.
//  Adds arbitrary (non-power-of-2) depth, a registered match result with the oldest-match offset,
//  and snoop-kill: matching entries are invalidated in place and silently dropped at the head.
//  Sits between a request producer and consumer where in-flight requests must be searched/cancelled.
// PARAMETERS
//  DEPTH    20  number of entries, >=2, any integer (not restricted to powers of 2)
//  DATA_W   32  entry width
//  SNOOP_W  16  key width; compared against wdata[SNOOP_W-1:0] of each entry, SNOOP_W<=DATA_W
//  AW       $clog2(DEPTH)  derived; index width (do not override)
// PORTS
//  clk         in   1        clock, all state on posedge
//  rstn        in   1        asynchronous reset, ACTIVE-HIGH (asserted = 1)
//  wdata       in   DATA_W   push data
//  wvalid      in   1        push request
//  wready      out  1        FIFO can accept (count<DEPTH and reset deasserted)
//  rdata       out  DATA_W   head entry data; 0 when rvalid=0
//  rvalid      out  1        head is occupied and not killed
//  rready      in   1        consumer accepts head
//  sdata       in   SNOOP_W  snoop key
//  svalid      in   1        snoop probe strobe
//  skill       in   1        with svalid: invalidate all matching live entries
//  smatch      out  1        registered: >=1 live entry matched the previous-cycle probe
//  smatch_off  out  AW       registered: offset from head of the oldest match; 0 if none
//  level       out  AW+1     occupied slots incl. killed-not-yet-dropped entries
// BEHAVIOUR
//  - Reset (rstn=1, async): rd_ptr=wr_ptr=0, count=0, all kill bits=0, storage=0; smatch=0,
//    smatch_off=0, level=0, rvalid=0, rdata=0, wready=0 while asserted, 1 on first cycle after.
//  - Pointers range 0..DEPTH-1, wrap explicitly DEPTH-1 -> 0; separate count register 0..DEPTH.
//  - push = wvalid & wready: mem[wr_ptr]<=wdata, kill[wr_ptr]<=0, wr_ptr++. wready=0 at count==DEPTH
//    even if a pop happens the same cycle (no full pass-through). wvalid while !wready: data ignored.
//  - pop = rvalid & rready, OR auto-drop when count>0 and kill[rd_ptr]=1 (rvalid=0 that cycle).
//    At most one entry leaves per cycle. No empty bypass: pushed data is visible at rvalid next cycle.
//  - count_next = count + push - leave; push and leave in the same cycle legal at any non-full level.
//  - Snoop: live entry = occupied and kill=0. Compare uses state BEFORE the same-edge push/pop/kill.
//    smatch/smatch_off update on the edge after svalid (1-cycle latency), cleared to 0 on the edge
//    after any cycle with svalid=0. Offset = (idx - rd_ptr) mod DEPTH of the oldest live match.
//  - Same-cycle push of matching data is NOT seen by the probe. Same-cycle pop of a matching head
//    IS reported (offset 0); kill on that head is moot since it leaves.
//  - skill&svalid: kill bit set on every live match at the same edge; killed entries keep occupying
//    slots (level unchanged) until they reach the head and are dropped, one per cycle.
//  - skill without svalid: ignored. Killed entries never match later probes.
//  - Reset mid-operation: all entries and pending snoop results discarded immediately.
// TESTING
//  1. Reset, push 0x11..0x24 (20 words, wvalid=1, rready=0) -> wready=0 after 20th, level=20;
//     21st word ignored; drain -> rdata 0x11..0x24 in order, rvalid=0, level=0.
//  2. Wrap: DEPTH=20, push/pop 45 words continuously with rready=1 -> order preserved, level<=1
//     steady state, rd_ptr wraps 19->0 twice with no data loss.
//  3. Fill with keys 0..19, probe sdata=0x0007 -> next cycle smatch=1, smatch_off=7; probe 0x0099
//     -> smatch=0, smatch_off=0.
//  4. Keys 3,5,3,8 queued, svalid+skill sdata=3 -> smatch_off=0; then rready=1 -> entries 0 and 2
//     dropped silently, consumer sees only 5 then 8; level 4->0 over 4 cycles.
//  5. Simultaneous: level=1 head key 0xA, push key 0xA + pop + probe 0xA same cycle -> smatch=1,
//     smatch_off=0; re-probe next cycle -> smatch=1, offset 0 (new entry). Assert rstn mid-drain ->
//     rvalid, smatch, level drop to 0 at once.

Source files
------------

// File: rtl/ah_snoopable_fifo_param.sv
// ah_snoopable_fifo_param
// Register-based valid/ready FIFO of arbitrary depth with a content snoop port.
// Every live entry's key field (low SNOOP_W bits) is compared against a probe.
// The result (hit flag and offset of the oldest hit from the head) is registered.
// With skill, matching entries are invalidated in place.
// Killed entries keep their slot and are dropped silently when they reach the head.
//
// Ports:
//   clk                 clock, all state on posedge
//   rstn                asynchronous reset, active-high
//   wdata/wvalid/wready push side
//   rdata/rvalid/rready pop side; rdata is 0 while rvalid is low
//   sdata/svalid/skill  snoop probe and kill request
//   smatch/smatch_off   registered snoop result for the previous-cycle probe
//   level               occupied slots, including killed entries not yet dropped
module ah_snoopable_fifo_param #(
    parameter int unsigned DEPTH   = 20,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned SNOOP_W = 16,
    localparam int unsigned AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [DATA_W-1:0] wdata,
    input  logic              wvalid,
    output logic              wready,
    output logic [DATA_W-1:0] rdata,
    output logic              rvalid,
    input  logic              rready,
    input  logic [SNOOP_W-1:0] sdata,
    input  logic              svalid,
    input  logic              skill,
    output logic              smatch,
    output logic [AW-1:0]     smatch_off,
    output logic [AW:0]       level
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0]  kill_q, kill_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW:0]       count_q, count_d;
    logic              smatch_q, smatch_d;
    logic [AW-1:0]     soff_q, soff_d;

    logic              push, leave;
    logic              found;
    logic [AW-1:0]     found_off;
    logic [DEPTH-1:0]  live_hit;
    logic [AW:0]       off_tmp;

    // Head is presented only when occupied and not killed.
    assign rvalid     = (count_q != '0) && !kill_q[rd_ptr_q];
    assign rdata      = rvalid ? mem_q[rd_ptr_q] : '0;
    assign wready     = !rstn && (count_q < (AW+1)'(DEPTH));
    assign push       = wvalid && wready;
    // A killed head leaves on its own; a live head leaves on rready.
    assign leave      = (count_q != '0) && (kill_q[rd_ptr_q] || rready);
    assign smatch     = smatch_q;
    assign smatch_off = soff_q;
    assign level      = count_q;

    // Snoop compare on pre-edge state: per slot, age from head, liveness and key hit.
    always_comb begin
        found     = 1'b0;
        found_off = '0;
        live_hit  = '0;
        off_tmp   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((AW+1)'(i) >= {1'b0, rd_ptr_q}) begin
                off_tmp = (AW+1)'(i) - {1'b0, rd_ptr_q};
            end else begin
                off_tmp = (AW+1)'(i) + (AW+1)'(DEPTH) - {1'b0, rd_ptr_q};
            end
            if ((off_tmp < count_q) && !kill_q[i] && (mem_q[i][SNOOP_W-1:0] == sdata)) begin
                live_hit[i] = 1'b1;
                if (!found || (off_tmp[AW-1:0] < found_off)) begin
                    found     = 1'b1;
                    found_off = off_tmp[AW-1:0];
                end
            end
        end
    end

    // Next-state for pointers, count, kill bits and snoop result.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        kill_d   = kill_q;
        smatch_d = 1'b0;
        soff_d   = '0;
        count_d  = count_q + (AW+1)'(push) - (AW+1)'(leave);
        if (svalid) begin
            smatch_d = found;
            soff_d   = found_off;
            if (skill) begin
                kill_d = kill_q | live_hit;
            end
        end
        // The push slot is never live, so clearing its kill bit cannot collide with a snoop kill.
        if (push) begin
            kill_d[wr_ptr_q] = 1'b0;
            wr_ptr_d = (wr_ptr_q == AW'(DEPTH - 1)) ? '0 : wr_ptr_q + AW'(1);
        end
        if (leave) begin
            rd_ptr_d = (rd_ptr_q == AW'(DEPTH - 1)) ? '0 : rd_ptr_q + AW'(1);
        end
    end

    // State and storage registers.
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            kill_q   <= '0;
            smatch_q <= 1'b0;
            soff_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            kill_q   <= kill_d;
            smatch_q <= smatch_d;
            soff_q   <= soff_d;
            if (push) begin
                mem_q[wr_ptr_q] <= wdata;
            end
        end
    end

endmodule

// File: tb/tb_ah_snoopable_fifo_param.sv
// Testbench for ah_snoopable_fifo_param (DEPTH=20, DATA_W=32, SNOOP_W=16).
// A queue-based reference model computes the expected outputs after every edge;
// a monitor pops them on the falling edge and compares against the DUT.
module tb_ah_snoopable_fifo_param;

    localparam int unsigned DEPTH = 20;
    localparam int unsigned AW    = 5;

    logic        clk = 1'b0;
    logic        rstn;
    logic [31:0] wdata;
    logic        wvalid;
    logic        wready;
    logic [31:0] rdata;
    logic        rvalid;
    logic        rready;
    logic [15:0] sdata;
    logic        svalid;
    logic        skill;
    logic        smatch;
    logic [AW-1:0] smatch_off;
    logic [AW:0] level;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic [31:0] d;
        bit          k;
    } ent_t;

    typedef struct packed {
        logic        rvalid;
        logic [31:0] rdata;
        logic [5:0]  level;
        logic        wready;
        logic        smatch;
        logic [4:0]  off;
    } exp_t;

    ent_t q[$];
    exp_t exp_q[$];

    ah_snoopable_fifo_param #(.DEPTH(20), .DATA_W(32), .SNOOP_W(16)) dut (
        .clk(clk), .rstn(rstn),
        .wdata(wdata), .wvalid(wvalid), .wready(wready),
        .rdata(rdata), .rvalid(rvalid), .rready(rready),
        .sdata(sdata), .svalid(svalid), .skill(skill),
        .smatch(smatch), .smatch_off(smatch_off), .level(level)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    // Reference model: FIFO as a queue of {data, killed}; evaluated on pre-edge inputs.
    always @(posedge clk) begin
        exp_t e;
        int   n;
        int   off;
        bit   hit;
        bit   lv;
        bit   acc;
        e = '0;
        if (rstn) begin
            q.delete();
        end else begin
            n   = q.size();
            hit = 0;
            off = 0;
            lv  = (n > 0) && (q[0].k || rready);
            acc = wvalid && (n < DEPTH);
            if (svalid) begin
                for (int j = 0; j < n; j++) begin
                    if (!q[j].k && q[j].d[15:0] == sdata) begin
                        if (!hit) off = j;
                        hit = 1;
                        if (skill) q[j].k = 1;
                    end
                end
            end
            if (lv) void'(q.pop_front());
            if (acc) q.push_back('{wdata, 1'b0});
            e.smatch = hit;
            e.off    = 5'(off);
            e.level  = 6'(q.size());
            e.rvalid = (q.size() > 0) && !q[0].k;
            e.rdata  = e.rvalid ? q[0].d : 32'h0;
            e.wready = q.size() < DEPTH;
        end
        exp_q.push_back(e);
    end

    // Monitor: one expected record per edge, compared away from the active edge.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("rvalid",     64'(rvalid),     64'(e.rvalid));
            chk("rdata",      64'(rdata),      64'(e.rdata));
            chk("level",      64'(level),      64'(e.level));
            chk("wready",     64'(wready),     64'(e.wready));
            chk("smatch",     64'(smatch),     64'(e.smatch));
            chk("smatch_off", 64'(smatch_off), 64'(e.off));
        end
    end

    task automatic cyc(input logic wv, input logic [31:0] wd, input logic rr,
                       input logic sv, input logic sk, input logic [15:0] sd);
        wvalid = wv;
        wdata  = wd;
        rready = rr;
        svalid = sv;
        skill  = sk;
        sdata  = sd;
        @(negedge clk);
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] got[$];
        rstn = 1'b1;
        wvalid = 0; wdata = 0; rready = 0; svalid = 0; skill = 0; sdata = 0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_wready", 64'(wready), 64'(0));
        chk("rst_level",  64'(level),  64'(0));
        rstn = 1'b0;
        #1;
        chk("wready_after_rst", 64'(wready), 64'(1));

        // 1: fill past full, then drain in order
        for (int i = 0; i < 21; i++) begin
            cyc(1, 32'h11 + 32'(i), 0, 0, 0, 0);
            if (i == 19) begin
                chk("t1_full_level",  64'(level),  64'(20));
                chk("t1_full_wready", 64'(wready), 64'(0));
            end
        end
        chk("t1_ignored_level", 64'(level), 64'(20));
        for (int i = 0; i < 20; i++) begin
            chk("t1_order", 64'(rdata), 64'(32'h11 + 32'(i)));
            cyc(0, 0, 1, 0, 0, 0);
        end
        chk("t1_empty_rvalid", 64'(rvalid), 64'(0));
        chk("t1_empty_level",  64'(level),  64'(0));

        // 2: continuous stream through the wrap point
        for (int i = 0; i < 45; i++) cyc(1, 32'h100 + 32'(i), 1, 0, 0, 0);
        chk("t2_level", 64'(level), 64'(1));
        chk("t2_last",  64'(rdata), 64'(32'h100 + 44));
        cyc(0, 0, 1, 0, 0, 0);

        // 3: snoop hit and miss on a full FIFO
        for (int i = 0; i < 20; i++) cyc(1, 32'(i), 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 16'h0007);
        chk("t3_hit",     64'(smatch),     64'(1));
        chk("t3_hit_off", 64'(smatch_off), 64'(7));
        cyc(0, 0, 0, 1, 0, 16'h0099);
        chk("t3_miss",     64'(smatch),     64'(0));
        chk("t3_miss_off", 64'(smatch_off), 64'(0));
        for (int i = 0; i < 20; i++) cyc(0, 0, 1, 0, 0, 0);

        // 4: snoop-kill, killed entries dropped silently
        cyc(1, 32'h3, 0, 0, 0, 0);
        cyc(1, 32'h5, 0, 0, 0, 0);
        cyc(1, 32'h3, 0, 0, 0, 0);
        cyc(1, 32'h8, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 1, 16'h3);
        chk("t4_hit",    64'(smatch),     64'(1));
        chk("t4_off",    64'(smatch_off), 64'(0));
        chk("t4_level",  64'(level),      64'(4));
        chk("t4_rvalid", 64'(rvalid),     64'(0));
        for (int i = 0; i < 4; i++) begin
            if (rvalid) got.push_back(rdata);
            cyc(0, 0, 1, 0, 0, 0);
        end
        chk("t4_ndeliv", 64'(got.size()), 64'(2));
        if (got.size() == 2) begin
            chk("t4_first",  64'(got[0]), 64'(5));
            chk("t4_second", 64'(got[1]), 64'(8));
        end
        chk("t4_level_end", 64'(level), 64'(0));

        // 5: push+pop+probe in one cycle, then reset mid-drain
        cyc(1, 32'hA, 0, 0, 0, 0);
        cyc(1, 32'hA, 1, 1, 0, 16'hA);
        chk("t5_hit",   64'(smatch),     64'(1));
        chk("t5_off",   64'(smatch_off), 64'(0));
        chk("t5_level", 64'(level),      64'(1));
        cyc(0, 0, 0, 1, 0, 16'hA);
        chk("t5_rehit", 64'(smatch),     64'(1));
        chk("t5_reoff", 64'(smatch_off), 64'(0));
        for (int i = 0; i < 5; i++) cyc(1, 32'hB0 + 32'(i), 0, 0, 0, 0);
        cyc(0, 0, 1, 1, 0, 16'hB4);
        cyc(0, 0, 1, 1, 0, 16'hB4);
        chk("t5_pre_rvalid", 64'(rvalid), 64'(1));
        chk("t5_pre_smatch", 64'(smatch), 64'(1));
        rstn = 1'b1;
        #1;
        chk("t5_rst_rvalid", 64'(rvalid), 64'(0));
        chk("t5_rst_smatch", 64'(smatch), 64'(0));
        chk("t5_rst_level",  64'(level),  64'(0));
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        rstn = 1'b0;

        // Random traffic with a small key space so probes and kills hit often
        for (int i = 0; i < 3000; i++) begin
            logic sv;
            sv = ($urandom_range(0, 9) < 3);
            cyc(($urandom_range(0, 9) < 6), {16'($urandom), 16'($urandom_range(0, 7))},
                ($urandom_range(0, 9) < 5), sv, sv && ($urandom_range(0, 9) < 3),
                16'($urandom_range(0, 7)));
        end
        for (int i = 0; i < 25; i++) cyc(0, 0, 1, 0, 0, 0);
        chk("final_level", 64'(level), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
